// File: rtl/controle_obstaculos.sv
// Per-frame obstacle scheduler: scrolls NUM_OBST line slots during vertical blanking.
// Optional random respawn (LFSR-driven x and length) is enabled with `define OBST_ALEATORIO_EN.
module controle_obstaculos #(
  parameter int NUM_OBST  = 4,
  parameter int VEL       = 2,
  parameter int COMPR_MIN = 64,
  parameter int LARGURA   = 8,
  parameter int Y_LIMITE  = 480
) (
  input  logic                    VGA_clk,
  input  logic                    reset_n,
  input  logic [9:0]              xCol,
  input  logic [8:0]              yRow,
  input  logic                    enable,
  output logic [10*NUM_OBST-1:0]  obst_x,
  output logic [9*NUM_OBST-1:0]   obst_y,
  output logic [10*NUM_OBST-1:0]  obst_comp,
  output logic [4:0]              obst_larg,
  output logic                    atualizando,
  output logic                    atualizado,
  output logic [7:0]              contador_frames
);

  localparam logic [9:0] Y_LIM_10  = 10'(Y_LIMITE);
  localparam logic [8:0] Y_LIM_9   = 9'(Y_LIMITE);
  localparam logic [9:0] VEL_10    = 10'(VEL);
  localparam logic [9:0] COMP_BASE = 10'(COMPR_MIN);
  localparam logic [2:0] IDX_LAST  = 3'(NUM_OBST - 1);
  localparam int         X_PASSO   = 640 / NUM_OBST;
  localparam int         Y_PASSO   = Y_LIMITE / NUM_OBST;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    ATUALIZA = 2'd1,
    FIM      = 2'd2
  } estado_t;

  estado_t    estado_q;
  logic [2:0] idx_q;
  logic       atualizando_q;
  logic       atualizado_q;
  logic [7:0] contador_q;

  // Edge-detect the frame condition so a multi-cycle match yields one tick.
  logic cond_d, cond_q, tick;
  assign cond_d = (yRow == Y_LIM_9) && (xCol == 10'd0);
  assign tick   = cond_d && !cond_q;

  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      cond_q <= 1'b0;
    end else begin
      cond_q <= cond_d;
    end
  end

  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q      <= ESPERA;
      idx_q         <= 3'd0;
      atualizando_q <= 1'b0;
      atualizado_q  <= 1'b0;
      contador_q    <= 8'd0;
    end else begin
      atualizado_q <= 1'b0;
      case (estado_q)
        ESPERA: begin
          if (tick && enable) begin
            estado_q      <= ATUALIZA;
            idx_q         <= 3'd0;
            atualizando_q <= 1'b1;
          end
        end
        ATUALIZA: begin
          if (idx_q == IDX_LAST) begin
            estado_q      <= FIM;
            atualizando_q <= 1'b0;
            atualizado_q  <= 1'b1;
            contador_q    <= contador_q + 8'd1;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        FIM: begin
          estado_q <= ESPERA;
        end
        default: begin
          estado_q      <= ESPERA;
          atualizando_q <= 1'b0;
        end
      endcase
    end
  end

  logic upd_en;
  assign upd_en = (estado_q == ATUALIZA);

`ifdef OBST_ALEATORIO_EN
  // Fibonacci LFSR, taps 16/14/13/11, free-running whenever out of reset.
  logic [15:0] lfsr_q;
  logic        lfsr_fb;
  logic [9:0]  rnd_x;
  logic [9:0]  rnd_comp;
  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign rnd_x    = {1'b0, lfsr_q[8:0]};
  assign rnd_comp = COMP_BASE + {3'b000, lfsr_q[15:9]};

  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OBST; gi++) begin : g_slot
      localparam logic [9:0] X_INI = 10'(gi * X_PASSO);
      localparam logic [8:0] Y_INI = 9'(gi * Y_PASSO);

      logic [8:0] y_q, y_d;
      logic [9:0] x_q, x_d;
      logic [9:0] comp_q, comp_d;
      logic [9:0] soma;
      logic [9:0] next_x;
      logic [9:0] next_comp;
      logic       sel;

`ifdef OBST_ALEATORIO_EN
      assign next_x    = rnd_x;
      assign next_comp = rnd_comp;
`else
      assign next_x    = X_INI;
      assign next_comp = COMP_BASE;
`endif

      assign sel  = upd_en && (idx_q == 3'(gi));
      // Sum is kept at 10 bits so y near 511 cannot alias below the limit.
      assign soma = {1'b0, y_q} + VEL_10;

      always_comb begin
        y_d    = y_q;
        x_d    = x_q;
        comp_d = comp_q;
        if (sel) begin
          if (soma < Y_LIM_10) begin
            y_d = soma[8:0];
          end else begin
            y_d    = 9'd0;
            x_d    = next_x;
            comp_d = next_comp;
          end
        end
      end

      always_ff @(posedge VGA_clk or negedge reset_n) begin
        if (!reset_n) begin
          y_q    <= Y_INI;
          x_q    <= X_INI;
          comp_q <= COMP_BASE;
        end else begin
          y_q    <= y_d;
          x_q    <= x_d;
          comp_q <= comp_d;
        end
      end

      assign obst_x[10*gi +: 10]    = x_q;
      assign obst_y[9*gi +: 9]      = y_q;
      assign obst_comp[10*gi +: 10] = comp_q;
    end
  endgenerate

  assign obst_larg       = 5'(LARGURA);
  assign atualizando     = atualizando_q;
  assign atualizado      = atualizado_q;
  assign contador_frames = contador_q;

endmodule

// File: tb/tb_controle_obstaculos.sv
// Directed bench for controle_obstaculos (NUM_OBST=4 defaults): frame vectors plus wrap and mid-pass reset.
module tb_controle_obstaculos;

  logic        VGA_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  xCol;
  logic [8:0]  yRow;
  logic        enable;
  logic [39:0] obst_x;
  logic [35:0] obst_y;
  logic [39:0] obst_comp;
  logic [4:0]  obst_larg;
  logic        atualizando;
  logic        atualizado;
  logic [7:0]  contador_frames;

  int checks = 0;
  int errors = 0;
  int frame_no = 0;
  logic [15:0] cap_lfsr;

  controle_obstaculos dut (
    .VGA_clk(VGA_clk), .reset_n(reset_n), .xCol(xCol), .yRow(yRow), .enable(enable),
    .obst_x(obst_x), .obst_y(obst_y), .obst_comp(obst_comp), .obst_larg(obst_larg),
    .atualizando(atualizando), .atualizado(atualizado), .contador_frames(contador_frames)
  );

  always #5 VGA_clk = ~VGA_clk;

`ifdef OBST_ALEATORIO_EN
  logic [15:0] ref_lfsr;
  always @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) ref_lfsr <= 16'hACE1;
    else ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
  end
`endif

  typedef struct {
    logic        en;
    logic [9:0]  xcol;
    logic [35:0] exp_y;
    logic [7:0]  exp_cnt;
    int          exp_pulses;
    int          exp_busy;
  } vec_t;

  function automatic logic [35:0] py(input int a, input int b, input int c, input int d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts on a negedge: holds the frame condition 3 cycles, then runs out 9 more.
  task automatic do_frame(input logic en, input logic [9:0] xc, output int pulses, output int busy);
    pulses = 0;
    busy = 0;
    enable = en;
    for (int c = 0; c < 12; c++) begin
      yRow = (c < 3) ? 9'd480 : 9'd0;
      xCol = (c < 3) ? xc : 10'd0;
      @(negedge VGA_clk);
      pulses += int'(atualizado);
      busy += int'(atualizando);
`ifdef OBST_ALEATORIO_EN
      if (c == 3) cap_lfsr = ref_lfsr;
`endif
    end
    frame_no++;
    $display("frame %0d en=%0b y=%h cnt=%0d pulses=%0d busy=%0d",
             frame_no, en, obst_y, contador_frames, pulses, busy);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_y"}, 64'(obst_y), 64'(py(0, 120, 240, 360)));
    chk({tag, "_x"}, 64'(obst_x), 64'({10'd480, 10'd320, 10'd160, 10'd0}));
    chk({tag, "_comp"}, 64'(obst_comp), 64'({4{10'd64}}));
    chk({tag, "_cnt"}, 64'(contador_frames), 64'd0);
    chk({tag, "_busy"}, 64'(atualizando), 64'd0);
    chk({tag, "_done"}, 64'(atualizado), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int p, b;
    vecs[0] = '{1'b1, 10'd0, py(2, 122, 242, 362), 8'd1, 1, 4};
    for (int i = 1; i <= 5; i++) vecs[i] = '{1'b0, 10'd0, py(2, 122, 242, 362), 8'd1, 0, 0};
    vecs[6] = '{1'b1, 10'd5, py(2, 122, 242, 362), 8'd1, 0, 0};
    vecs[7] = '{1'b1, 10'd0, py(4, 124, 244, 364), 8'd2, 1, 4};

    reset_n = 1'b0;
    enable = 1'b0;
    xCol = 10'd0;
    yRow = 9'd0;
    repeat (3) @(negedge VGA_clk);
    check_reset_state("reset");
    chk("larg", 64'(obst_larg), 64'd8);
    reset_n = 1'b1;
    @(negedge VGA_clk);

    for (int i = 0; i < 8; i++) begin
      do_frame(vecs[i].en, vecs[i].xcol, p, b);
      chk($sformatf("v%0d_y", i), 64'(obst_y), 64'(vecs[i].exp_y));
      chk($sformatf("v%0d_cnt", i), 64'(contador_frames), 64'(vecs[i].exp_cnt));
      chk($sformatf("v%0d_pulses", i), 64'(p), 64'(vecs[i].exp_pulses));
      chk($sformatf("v%0d_busy", i), 64'(b), 64'(vecs[i].exp_busy));
    end

    // Scroll slot 3 up to 478, then one more pass wraps it.
    for (int i = 0; i < 57; i++) do_frame(1'b1, 10'd0, p, b);
    chk("pre_wrap_y", 64'(obst_y), 64'(py(118, 238, 358, 478)));
    chk("pre_wrap_cnt", 64'(contador_frames), 64'd59);
    do_frame(1'b1, 10'd0, p, b);
    chk("wrap_y", 64'(obst_y), 64'(py(120, 240, 360, 0)));
    chk("wrap_cnt", 64'(contador_frames), 64'd60);
    chk("wrap_pulses", 64'(p), 64'd1);
    chk("wrap_x012", 64'(obst_x[29:0]), 64'({10'd320, 10'd160, 10'd0}));
`ifdef OBST_ALEATORIO_EN
    chk("wrap_x3", 64'(obst_x[39:30]), 64'({1'b0, cap_lfsr[8:0]}));
    chk("wrap_comp3", 64'(obst_comp[39:30]), 64'(10'd64 + {3'b000, cap_lfsr[15:9]}));
    chk("wrap_fit", 64'((32'(obst_x[39:30]) + 32'(obst_comp[39:30])) < 640), 64'd1);
`else
    chk("wrap_x3", 64'(obst_x[39:30]), 64'd480);
    chk("wrap_comp3", 64'(obst_comp[39:30]), 64'd64);
`endif

    // Reset during the second ATUALIZA cycle.
    enable = 1'b1;
    yRow = 9'd480;
    xCol = 10'd0;
    @(negedge VGA_clk);
    chk("mid_busy_before", 64'(atualizando), 64'd1);
    @(posedge VGA_clk);
    #1 reset_n = 1'b0;
    #1;
    check_reset_state("midreset");
    $display("mid-pass reset y=%h cnt=%0d", obst_y, contador_frames);
    @(negedge VGA_clk);
    yRow = 9'd0;
    reset_n = 1'b1;
    @(negedge VGA_clk);
    do_frame(1'b1, 10'd0, p, b);
    chk("post_reset_y", 64'(obst_y), 64'(py(2, 122, 242, 362)));
    chk("post_reset_cnt", 64'(contador_frames), 64'd1);
    chk("post_reset_pulses", 64'(p), 64'd1);
    chk("post_reset_busy", 64'(b), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
